// File: rtl/pm_loader_if.sv
// Host byte-stream handshake into the program memory loader; master is the host side.
interface pm_loader_if #(
    parameter int DATA_W = 8
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;

    modport master (output host_valid, output host_data, input host_ready);
    modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/pm_loader.sv
// Fills program memory from LEN/payload[/CSUM] host frames while holding the CPU in reset; write lands 1 cycle after accept.
// host_ready is registered, high only in LEN/DATA/CSUM; PM_LOADER_CSUM_EN adds the trailing checksum byte.
module pm_loader #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    pm_loader_if.slave        host,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [DATA_W-1:0] pm_wr_data,
    output logic              pm_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL_IMAGE = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   n_len;
    logic [TW-1:0]     tcnt;
    logic              accept;
    logic              last_byte;
    logic [ADDR_W:0]   words_next;
`ifdef PM_LOADER_CSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;

    assign sum_next = sum + host.host_data;
`endif

    assign host.host_ready = ready_q;
    assign accept          = host.host_valid & ready_q;
    assign words_next      = words_loaded + 1'b1;
    assign last_byte       = (words_next == n_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            ready_q      <= 1'b0;
            addr         <= '0;
            n_len        <= '0;
            tcnt         <= '0;
            pm_wr_addr   <= '0;
            pm_wr_data   <= '0;
            pm_wren      <= 1'b0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
`ifdef PM_LOADER_CSUM_EN
            sum          <= '0;
`endif
        end else begin
            pm_wren   <= 1'b0;
            load_done <= 1'b0;
            // ready_q doubles as "frame open": idle cycles count only while bytes are expected
            tcnt      <= (ready_q && !accept) ? tcnt + 1'b1 : '0;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN;
                        ready_q      <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
`ifdef PM_LOADER_CSUM_EN
                        sum          <= '0;
`endif
                    end else if (state == S_DONE) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        n_len <= (host.host_data == '0) ? FULL_IMAGE
                                                        : (ADDR_W + 1)'(host.host_data);
                        addr  <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        pm_wren      <= 1'b1;
                        pm_wr_addr   <= addr;
                        pm_wr_data   <= host.host_data;
                        addr         <= addr + 1'b1;
                        words_loaded <= words_next;
`ifdef PM_LOADER_CSUM_EN
                        sum          <= sum_next;
                        if (last_byte) begin
                            state <= S_CSUM;
                        end
`else
                        if (last_byte) begin
                            state     <= S_DONE;
                            ready_q   <= 1'b0;
                            load_done <= 1'b1;
                        end
`endif
                    end
                end
`ifdef PM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (sum_next == '0) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase

            // An abandoned frame leaves whatever was already written in memory
            if (ready_q && !accept && tcnt == T_LAST) begin
                state    <= S_ERR;
                ready_q  <= 1'b0;
                load_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pm_loader.sv
// Directed + randomized frames against a queue-based image/checksum model of the loader.
module tb_pm_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;
    logic       pm_wren;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [8:0] words_loaded;

    pm_loader_if #(.DATA_W(8)) host ();

    pm_loader #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .host(host),
        .pm_wr_addr(pm_wr_addr),
        .pm_wr_data(pm_wr_data),
        .pm_wren(pm_wren),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed write stream and done pulses, sampled at the end of each cycle
    logic [15:0] wr_q[$];
    int          done_cnt = 0;
    int          wr_base  = 0;
    int          done_base = 0;

    always @(posedge clk) begin
        if (pm_wren) wr_q.push_back({pm_wr_addr, pm_wr_data});
        if (load_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference checksum: the byte that brings the frame sum to zero mod 256
    function automatic logic [7:0] csum_of(input logic [7:0] p[$]);
        int s;
        s = 0;
        foreach (p[i]) s += int'(p[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Entered at a falling edge; returns at the falling edge after the accepting rising edge
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int w;
        w = 0;
        host.host_valid = 1'b1;
        host.host_data  = b;
        while (!host.host_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = host.host_ready;
        @(negedge clk);
        host.host_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] len_b, input logic [7:0] pay[$], input logic [7:0] csum_b,
                             input int gap_max, input bit toggle, input bit early_valid);
        bit ok;
        wr_base   = wr_q.size();
        done_base = done_cnt;
        start = 1'b1;
        if (early_valid) begin
            host.host_valid = 1'b1;
            host.host_data  = len_b;
        end
        @(negedge clk);
        start = 1'b0;
        chk("start_state", {host.host_ready, cpu_hold, load_err, words_loaded}, {1'b1, 1'b1, 1'b0, 9'd0});
        send_byte(len_b, ok);
        chk("len_accept", 32'(ok), 32'd1);
        for (int i = 0; i < pay.size(); i++) begin
            int gap;
            if (toggle) gap = (i > 0) ? 1 : 0;
            else gap = int'($urandom_range(gap_max, 0));
            repeat (gap) @(negedge clk);
            send_byte(pay[i], ok);
            chk("wr_timing", {ok, pm_wren, pm_wr_addr, pm_wr_data}, {1'b1, 1'b1, 8'(i), pay[i]});
        end
`ifdef PM_LOADER_CSUM_EN
        send_byte(csum_b, ok);
        chk("csum_accept", 32'(ok), 32'd1);
`else
        if (csum_b == 8'hxx) $display("unexpected csum operand");
`endif
    endtask

    task automatic finish_frame(input bit exp_ok, input logic [7:0] pay[$]);
        chk("end_flags", {load_done, load_err, cpu_hold}, {exp_ok, !exp_ok, 1'b1});
        @(negedge clk);
        chk("after_end", {load_done, cpu_hold, host.host_ready}, {1'b0, !exp_ok, 1'b0});
        chk("done_count", 32'(done_cnt - done_base), exp_ok ? 32'd1 : 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(pay.size()));
        chk("wr_count", 32'(wr_q.size() - wr_base), 32'(pay.size()));
        for (int i = 0; i < pay.size() && wr_base + i < wr_q.size(); i++)
            chk("image", 32'(wr_q[wr_base + i]), {16'd0, 8'(i), pay[i]});
    endtask

    initial begin
        logic [7:0] pay[$];
        bit         ok;
        bit         bad_ok;
        int         n;

        reset = 1'b1;
        start = 1'b0;
        host.host_valid = 1'b0;
        host.host_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(host.host_ready), 32'd0);
        chk("rst_write", {pm_wren, pm_wr_addr, pm_wr_data}, 17'd0);
        chk("rst_status", {cpu_hold, load_done, load_err, words_loaded}, 12'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal frame
        pay = {8'hA5, 8'h0F, 8'h31};
        run_frame(8'h03, pay, 8'h1B, 0, 1'b0, 1'b0);
        finish_frame(1'b1, pay);

        // Bad checksum, then a good random frame clears the error
`ifdef PM_LOADER_CSUM_EN
        bad_ok = 1'b0;
`else
        bad_ok = 1'b1;
`endif
        run_frame(8'h03, pay, 8'h1C, 0, 1'b0, 1'b0);
        finish_frame(bad_ok, pay);
        repeat (3) @(negedge clk);
        chk("err_hold", {load_err, cpu_hold, load_done}, {!bad_ok, !bad_ok, 1'b0});
        pay = {};
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
        run_frame(8'h05, pay, csum_of(pay), 2, 1'b0, 1'b0);
        finish_frame(1'b1, pay);

        // Host throttling: valid toggles every cycle
        pay = {};
        for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
        run_frame(8'h06, pay, csum_of(pay), 0, 1'b1, 1'b0);
        finish_frame(1'b1, pay);

        // Random frames with random gaps
        for (int f = 0; f < 3; f++) begin
            n = int'($urandom_range(20, 1));
            pay = {};
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            run_frame(8'(n), pay, csum_of(pay), 3, 1'b0, 1'b0);
            finish_frame(1'b1, pay);
        end

        // Timeout after 1 of 4 bytes; a start inside the frame is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, ok);
        chk("to_len", 32'(ok), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h5A, ok);
        chk("to_first_wr", {ok, pm_wren, pm_wr_addr, pm_wr_data}, {1'b1, 1'b1, 8'h00, 8'h5A});
        repeat (15) @(negedge clk);
        chk("to_before", {load_err, host.host_ready}, 2'b01);
        @(negedge clk);
        chk("to_err", {load_err, host.host_ready, cpu_hold, words_loaded}, {1'b1, 1'b0, 1'b1, 9'd1});

        // Reset mid-frame, right after a write
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h05, ok);
        send_byte(8'h11, ok);
        send_byte(8'h22, ok);
        chk("pre_rst_wr", {pm_wren, pm_wr_addr, pm_wr_data}, {1'b1, 8'h01, 8'h22});
        #3 reset = 1'b1;
        #1;
        chk("arst_ready", 32'(host.host_ready), 32'd0);
        chk("arst_write", {pm_wren, pm_wr_addr, pm_wr_data}, 17'd0);
        chk("arst_status", {cpu_hold, load_done, load_err, words_loaded}, 12'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_base = wr_q.size();
        host.host_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host.host_data = 8'(i + 1);
            @(negedge clk);
        end
        host.host_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_writes", 32'(wr_q.size() - wr_base), 32'd0);
        chk("post_rst_idle", {host.host_ready, cpu_hold}, 2'b00);

        // start and host_valid together in IDLE: the byte waits for LEN
        pay = {8'h3C, 8'hC7};
        run_frame(8'h02, pay, csum_of(pay), 0, 1'b0, 1'b1);
        finish_frame(1'b1, pay);

        // Full image: LEN=0 means 256 words, byte k at address k
        pay = {};
        for (int k = 0; k < 256; k++) pay.push_back(8'(k));
        chk("model_full_csum", 32'(csum_of(pay)), 32'h80);
        run_frame(8'h00, pay, 8'h80, 0, 1'b0, 1'b0);
        finish_frame(1'b1, pay);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
